// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants for writeback destination selection.
// The control unit uses the same select encodings.
package wb_dest_pipe_pkg;

    localparam logic [2:0] SEL_RT = 3'd0;
    localparam logic [2:0] SEL_RD = 3'd1;
    localparam logic [2:0] SEL_RS = 3'd2;
    localparam logic [2:0] SEL_SP = 3'd3;
    localparam logic [2:0] SEL_RA = 3'd4;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;

endpackage

// File: rtl/wb_dest_pipe_if.sv
// Decode-side bundle for the writeback destination pipe.
// The master drives issue and hazard queries; the slave returns the writeback and scoreboard state.
interface wb_dest_pipe_if #(
    parameter int REG_AW = 5
);
    logic                 issue;
    logic [2:0]           sel;
    logic [REG_AW-1:0]    rt;
    logic [REG_AW-1:0]    rd;
    logic [REG_AW-1:0]    rs;
    logic                 flush;
    logic [REG_AW-1:0]    chk_a;
    logic [REG_AW-1:0]    chk_b;
    logic                 wb_en;
    logic [REG_AW-1:0]    wb_dest;
    logic                 hazard_a;
    logic                 hazard_b;
    logic [2**REG_AW-1:0] busy_vec;
    logic                 err_sel;

    modport master (
        output issue, sel, rt, rd, rs,
        output flush, chk_a, chk_b,
        input  wb_en, wb_dest,
        input  hazard_a, hazard_b,
        input  busy_vec, err_sel
    );

    modport slave (
        input  issue, sel, rt, rd, rs,
        input  flush, chk_a, chk_b,
        output wb_en, wb_dest,
        output hazard_a, hazard_b,
        output busy_vec, err_sel
    );
endinterface

// File: rtl/wb_dest_pipe_decode.sv
// Combinational select-to-destination decode.
// Selects 5..7 are illegal and decode to register 0.
module wb_dest_decode
    import wb_dest_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SP_IDX = 29,
    parameter int RA_IDX = 31
) (
    input  logic [2:0]        sel_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] rs_i,
    output logic [REG_AW-1:0] dest_o,
    output logic              legal_o
);
    always_comb begin
        dest_o  = '0;
        legal_o = 1'b1;
        unique case (1'b1)
            (sel_i == SEL_RT): dest_o = rt_i;
            (sel_i == SEL_RD): dest_o = rd_i;
            (sel_i == SEL_RS): dest_o = rs_i;
            (sel_i == SEL_SP): dest_o = REG_AW'(SP_IDX);
            (sel_i == SEL_RA): dest_o = REG_AW'(RA_IDX);
            default:           legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/wb_dest_pipe.sv
// Writeback destination delay line with a pending-write scoreboard.
// Stage LAT-1 drives the register bank write port.
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LAT    = 3,
    parameter int SP_IDX = 29,
    parameter int RA_IDX = 31
) (
    input logic           clk,
    input logic           reset,
    wb_dest_pipe_if.slave bus
);
    localparam int NREG = 2**REG_AW;

    logic [REG_AW-1:0] dec_dest;
    logic              dec_legal;
    logic              vld_d;
    logic              err_sel_q;
    logic [NREG-1:0]   busy;

    logic              stg_vld [LAT];
    logic [REG_AW-1:0] stg_dst [LAT];

    wb_dest_decode #(
        .REG_AW (REG_AW),
        .SP_IDX (SP_IDX),
        .RA_IDX (RA_IDX)
    ) u_decode (
        .sel_i   (bus.sel),
        .rt_i    (bus.rt),
        .rd_i    (bus.rd),
        .rs_i    (bus.rs),
        .dest_o  (dec_dest),
        .legal_o (dec_legal)
    );

    // Writes to register 0 are discarded at entry so they never look busy.
    assign vld_d = bus.issue & dec_legal & (dec_dest != '0) & ~bus.flush;

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        logic              vld_q;
        logic [REG_AW-1:0] dst_q;

        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= 1'b0;
                    dst_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dst_q <= dec_dest;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= 1'b0;
                    dst_q <= '0;
                end else begin
                    vld_q <= stg_vld[k-1] & ~bus.flush;
                    dst_q <= stg_dst[k-1];
                end
            end
        end

        assign stg_vld[k] = vld_q;
        assign stg_dst[k] = dst_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= bus.issue & ~dec_legal;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < LAT; i++) begin
            if (stg_vld[i]) begin
                busy[stg_dst[i]] = 1'b1;
            end
        end
    end

    assign bus.busy_vec = busy;
    assign bus.hazard_a = busy[bus.chk_a];
    assign bus.hazard_b = busy[bus.chk_b];
    assign bus.wb_en    = stg_vld[LAT-1];
    assign bus.wb_dest  = stg_dst[LAT-1];
    assign bus.err_sel  = err_sel_q;
endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe at LAT=3 and LAT=1.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_wb_dest_pipe;
    import wb_dest_pipe_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    wb_dest_pipe_if #(.REG_AW(5)) bus ();
    wb_dest_pipe_if #(.REG_AW(5)) bus1 ();

    wb_dest_pipe #(
        .REG_AW (5),
        .LAT    (3),
        .SP_IDX (29),
        .RA_IDX (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_dest_pipe #(
        .REG_AW (5),
        .LAT    (1),
        .SP_IDX (29),
        .RA_IDX (31)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue = 1'b0;
        bus.sel   = SEL_RT;
        bus.rt    = '0;
        bus.rd    = '0;
        bus.rs    = '0;
        bus.flush = 1'b0;
        bus.chk_a = '0;
        bus.chk_b = '0;
    endtask

    task automatic issue_rd(input logic [4:0] r);
        bus.issue = 1'b1;
        bus.sel   = SEL_RD;
        bus.rd    = r;
    endtask

    task automatic test_reset();
        idle();
        bus1.issue = 1'b0;
        bus1.sel   = SEL_RT;
        bus1.rt    = '0;
        bus1.rd    = '0;
        bus1.rs    = '0;
        bus1.flush = 1'b0;
        bus1.chk_a = '0;
        bus1.chk_b = '0;
        reset = 1'b0;
        #12;
        checks++;
        if (bus.wb_en !== 1'b0 || bus.wb_dest !== 5'd0) begin
            errors++;
            $display("FAIL reset_wb: en=%b dest=%0d want 0/0", bus.wb_en, bus.wb_dest);
        end
        checks++;
        if (bus.busy_vec !== 32'h0 || bus.err_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy=%h err=%b want 0/0", bus.busy_vec, bus.err_sel);
        end
        checks++;
        if (bus1.wb_en !== 1'b0 || bus1.busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_lat1: en=%b busy=%h want 0/0", bus1.wb_en, bus1.busy_vec);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic       en_exp [4];
        logic       bz_exp [4];
        en_exp = '{1'b0, 1'b0, 1'b1, 1'b0};
        bz_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        issue_rd(5'd8);
        for (int t = 0; t < 4; t++) begin
            tick();
            idle();
            checks++;
            if (bus.wb_en !== en_exp[t] || (en_exp[t] && bus.wb_dest !== 5'd8)) begin
                errors++;
                $display("FAIL single_wb[%0d]: en=%b dest=%0d want %b/8", t, bus.wb_en, bus.wb_dest, en_exp[t]);
            end
            checks++;
            if (bus.busy_vec[8] !== bz_exp[t]) begin
                errors++;
                $display("FAIL single_busy[%0d]: busy8=%b want %b", t, bus.busy_vec[8], bz_exp[t]);
            end
        end
    endtask

    task automatic test_sel_all();
        logic [4:0] dexp [5];
        dexp = '{5'd3, 5'd4, 5'd5, 5'd29, 5'd31};
        for (int t = 0; t < 8; t++) begin
            if (t < 5) begin
                bus.issue = 1'b1;
                bus.sel   = 3'(t);
                bus.rt    = 5'd3;
                bus.rd    = 5'd4;
                bus.rs    = 5'd5;
            end else begin
                idle();
            end
            tick();
            if (t >= 2 && t <= 6) begin
                checks++;
                if (bus.wb_en !== 1'b1 || bus.wb_dest !== dexp[t-2]) begin
                    errors++;
                    $display("FAIL sel_wb[%0d]: en=%b dest=%0d want 1/%0d", t, bus.wb_en, bus.wb_dest, dexp[t-2]);
                end
            end else begin
                checks++;
                if (bus.wb_en !== 1'b0) begin
                    errors++;
                    $display("FAIL sel_idle[%0d]: en=%b want 0", t, bus.wb_en);
                end
            end
            if (t == 4) begin
                checks++;
                if (bus.busy_vec !== 32'hA000_0020) begin
                    errors++;
                    $display("FAIL sel_busy: busy=%h want a0000020", bus.busy_vec);
                end
            end
        end
        idle();
    endtask

    task automatic test_zero_illegal();
        bus.issue = 1'b1;
        bus.sel   = SEL_RT;
        bus.rt    = 5'd0;
        tick();
        idle();
        checks++;
        if (bus.busy_vec !== 32'h0 || bus.err_sel !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: busy=%h err=%b want 0/0", bus.busy_vec, bus.err_sel);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL zero_wb[%0d]: en=%b want 0", t, bus.wb_en);
            end
        end
        bus.issue = 1'b1;
        bus.sel   = 3'd6;
        bus.rd    = 5'd9;
        tick();
        idle();
        checks++;
        if (bus.err_sel !== 1'b1 || bus.busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL illegal_err: err=%b busy=%h want 1/0", bus.err_sel, bus.busy_vec);
        end
        bus.sel = 3'd7;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (bus.err_sel !== 1'b0 || bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL illegal_after[%0d]: err=%b en=%b want 0/0", t, bus.err_sel, bus.wb_en);
            end
        end
        idle();
    endtask

    task automatic test_raw_hazard();
        logic hz_exp [6];
        logic en_exp [6];
        hz_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        en_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 6; t++) begin
            if (t == 0 || t == 2) issue_rd(5'd12);
            else bus.issue = 1'b0;
            bus.chk_a = 5'd12;
            bus.chk_b = 5'd13;
            tick();
            checks++;
            if (bus.hazard_a !== hz_exp[t] || bus.hazard_b !== 1'b0) begin
                errors++;
                $display("FAIL raw_hz[%0d]: a=%b b=%b want %b/0", t, bus.hazard_a, bus.hazard_b, hz_exp[t]);
            end
            checks++;
            if (bus.wb_en !== en_exp[t] || (en_exp[t] && bus.wb_dest !== 5'd12)) begin
                errors++;
                $display("FAIL raw_wb[%0d]: en=%b dest=%0d want %b/12", t, bus.wb_en, bus.wb_dest, en_exp[t]);
            end
        end
        idle();
    endtask

    task automatic test_flush();
        issue_rd(5'd7);
        tick();
        issue_rd(5'd9);
        tick();
        issue_rd(5'd10);
        tick();
        bus.flush = 1'b1;
        issue_rd(5'd11);
        #1;
        checks++;
        if (bus.wb_en !== 1'b1 || bus.wb_dest !== 5'd7 || bus.busy_vec !== 32'h0000_0680) begin
            errors++;
            $display("FAIL flush_pre: en=%b dest=%0d busy=%h want 1/7/00000680", bus.wb_en, bus.wb_dest, bus.busy_vec);
        end
        tick();
        idle();
        checks++;
        if (bus.busy_vec !== 32'h0 || bus.wb_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: busy=%h en=%b want 0/0", bus.busy_vec, bus.wb_en);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL flush_wb[%0d]: en=%b dest=%0d want 0", t, bus.wb_en, bus.wb_dest);
            end
        end
        bus.flush = 1'b1;
        bus.issue = 1'b1;
        bus.sel   = 3'd7;
        tick();
        idle();
        checks++;
        if (bus.err_sel !== 1'b1 || bus.busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL flush_err: err=%b busy=%h want 1/0", bus.err_sel, bus.busy_vec);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue_rd(5'd14);
        tick();
        issue_rd(5'd15);
        tick();
        issue_rd(5'd16);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.wb_en !== 1'b0 || bus.busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: en=%b busy=%h want 0/0", bus.wb_en, bus.busy_vec);
        end
        tick();
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL rst_after[%0d]: en=%b want 0", t, bus.wb_en);
            end
        end
    endtask

    task automatic test_lat1();
        bus1.issue = 1'b1;
        bus1.sel   = SEL_RD;
        bus1.rd    = 5'd6;
        bus1.chk_a = 5'd6;
        tick();
        bus1.issue = 1'b0;
        checks++;
        if (bus1.wb_en !== 1'b1 || bus1.wb_dest !== 5'd6) begin
            errors++;
            $display("FAIL lat1_wb: en=%b dest=%0d want 1/6", bus1.wb_en, bus1.wb_dest);
        end
        checks++;
        if (bus1.hazard_a !== 1'b1 || bus1.busy_vec !== 32'h0000_0040) begin
            errors++;
            $display("FAIL lat1_hz: hz=%b busy=%h want 1/00000040", bus1.hazard_a, bus1.busy_vec);
        end
        tick();
        checks++;
        if (bus1.wb_en !== 1'b0 || bus1.hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL lat1_done: en=%b hz=%b want 0/0", bus1.wb_en, bus1.hazard_a);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        #1;
        test_reset();
        test_single();
        test_sel_all();
        test_zero_illegal();
        test_raw_hazard();
        test_flush();
        test_reset_mid();
        test_lat1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_dest_pipe.md
Name: wb_dest_pipe

Overview:
Parametrised successor to the register-bank write-destination selector. It picks the destination register from rt/rd/rs or a fixed SP/RA index, then carries it through a LAT-stage delay line that matches the datapath's writeback latency. It also keeps a per-register pending-write scoreboard so decode can detect RAW hazards. It sits between control-unit decode and the register bank write port.

Parameters:
REG_AW, 5, register index width (bank has 2**REG_AW registers)
LAT, 3, cycles from issue to write-back, legal range 1..8
SP_IDX, 29, index written when sel=3
RA_IDX, 31, index written when sel=4 (link register)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
issue  in  1  the instruction in decode writes a register this cycle
sel  in  3  destination select: 0 rt, 1 rd, 2 rs, 3 SP_IDX, 4 RA_IDX, 5..7 illegal
rt  in  REG_AW  instruction rt field
rd  in  REG_AW  instruction rd field
rs  in  REG_AW  instruction rs field
flush  in  1  discard all in-flight writes
chk_a  in  REG_AW  first source register to hazard-check
chk_b  in  REG_AW  second source register to hazard-check
wb_en  out  1  write-enable to the register bank
wb_dest  out  REG_AW  write address to the register bank
hazard_a  out  1  chk_a has a pending write
hazard_b  out  1  chk_b has a pending write
busy_vec  out  2**REG_AW  bit i set means register i has at least one pending write
err_sel  out  1  one-cycle pulse on an illegal sel

Behaviour:
- Reset, asserted asynchronously: all stage valid bits 0, all stage dests 0, wb_en=0, wb_dest=0, err_sel=0.
- Decode is combinational from sel and the fields. sel 5..7 gives an invalid destination.
- Pipeline: LAT stages, each holding {valid, dest}, stage 0 to stage LAT-1.
- At each clk edge:
  - stage 0 loads valid = issue & legal sel & (dest != 0), and the decoded dest.
  - stage k loads stage k-1.
- wb_en and wb_dest are driven straight from stage LAT-1. Latency is exactly LAT cycles: an issue sampled at edge n gives wb_en high for cycle n+LAT-1 to n+LAT.
- Register 0 is hardwired zero. A write to dest 0 enters the pipe with valid=0: no wb_en, no scoreboard entry.
- Illegal sel with issue=1: the entry is dropped and err_sel is registered high for exactly one cycle. With issue=0, err_sel stays 0.
- The pipe is a pure delay line with no back-pressure. A new issue is accepted every cycle.
- Scoreboard:
  - busy_vec is the OR over all stages of (valid ? onehot(dest) : 0).
  - The stage currently presenting wb_en counts as busy. There is no forwarding.
- hazard_a = busy_vec[chk_a], hazard_b = busy_vec[chk_b]. Both are combinational from registered state, with no input-to-output path through issue.
- Several in-flight writes to the same register are legal. The register stays busy until the last one retires.
- flush: at the next edge every valid bit clears, including stage LAT-1.
  - Outputs in the flush cycle itself are unaffected.
  - flush together with issue: flush wins and the issue is dropped.
  - err_sel still pulses if that issue had an illegal sel.
- LAT=1: stage 0 is also the output stage, and the hazard window is one cycle.
- Reset mid-operation: all pending writes are lost immediately, with no write-back after reset is released.

Decomposition:
- Shared package/header: select encodings SEL_RT=0, SEL_RD=1, SEL_RS=2, SEL_SP=3, SEL_RA=4. The control unit and this block use the same constants.
- One natural sub-module: wb_dest_decode, the combinational sel-to-dest decode plus illegal flag.
- The pipe and scoreboard stay in the top module, using a generate loop over LAT.

Test Plan:
- Defaults, reset release, issue=1 sel=1 rd=8 at edge 0 -> wb_en=1, wb_dest=8 in the cycle after edge 2; busy_vec[8]=1 from after edge 0 until after edge 3.
- Each sel 0..4 with rt=3, rd=4, rs=5 -> wb_dest 3, 4, 5, 29, 31 in order, one per cycle back-to-back; wb_en high for 5 consecutive cycles.
- issue with sel=0, rt=0 -> wb_en never rises and busy_vec[0] stays 0. issue with sel=6 -> err_sel high for one cycle, no write-back.
- Two issues to reg 12 two cycles apart, chk_a=12 -> hazard_a high continuously for 5 cycles, then low; wb_en pulses twice.
- Fill the pipe with dests 7, 9, 10, assert flush together with issue (dest 11) -> busy_vec=0 after the edge, no wb_en afterwards, 11 never written.
- Pipe full, assert reset mid-cycle -> wb_en and busy_vec drop to 0 immediately without a clock. Repeat with LAT=1: issue dest 6 -> wb_en in the very next cycle.
